pwm_soft_start_seq: RTL

Per-channel soft-start and fault-recovery sequencer for one PWM FET driver unit. It owns the unit's RESET_n and PWM duty inputs: it releases the unit from reset, ramps duty from 0 to a programmed target in steps aligned to PWM cycle boundaries, and tracks later target changes. On FAULT_DETECT it shuts the unit down, cools down, and retries up to a limit before latching a lockout. One instance per channel sits between the Wishbone register block and the driver unit.

---
 rtl/pwm_seq_pkg.sv | 12 +
 rtl/pwm_step_timer.sv | 25 ++
 rtl/pwm_soft_start_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: state encodings and shared constants for the PWM soft-start sequencer
package pwm_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_RAMP    = 3'd2,
        S_RUN     = 3'd3,
        S_COOL    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;
    localparam int unsigned EFF_MIN = 1;
endpackage

// File: rtl/pwm_step_timer.sv
// pwm_step_timer: divider counter with terminal count at an effective (zero-as-one) divide value
module pwm_step_timer
    import pwm_seq_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tc
);
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_eff;
    assign w_eff = (i_div == '0) ? DIV_W'(EFF_MIN) : i_div;
    assign o_tc  = i_inc && (r_cnt == w_eff - 1'b1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/pwm_soft_start_seq.sv
// pwm_soft_start_seq: per-channel soft-start ramp, fault cool-down/retry and lockout sequencer
module pwm_soft_start_seq
    import pwm_seq_pkg::*;
#(
    parameter int PWM_W     = 8,
    parameter int DIV_W     = 16,
    parameter int RETRY_MAX = 3,
    parameter int RTY_W     = 2
) (
    input  logic             wb_clk_i,
    input  logic             RESET_n,
    input  logic             ENABLE,
    input  logic [PWM_W-1:0] TARGET_PWM,
    input  logic [3:0]       STEP_SIZE,
    input  logic [DIV_W-1:0] STEP_DIV,
    input  logic [DIV_W-1:0] COOL_DIV,
    input  logic             CLR_LOCKOUT,
    input  logic             CYCLE,
    input  logic             FAULT_DETECT,
    output logic             DRV_RESET_n,
    output logic [PWM_W-1:0] DRV_PWM,
    output logic [2:0]       STATE,
    output logic             AT_TARGET,
    output logic             LOCKOUT,
    output logic [RTY_W-1:0] RETRY_CNT,
    output logic             FAULT_IRQ
);
    state_t           r_state;
    logic [PWM_W-1:0] r_pwm;
    logic             r_rst_n, r_at, r_lock, r_irq;
    logic [RTY_W-1:0] r_retry;
    logic             w_step_tc, w_cool_tc, w_active, w_fault, w_disable;
    logic [3:0]       w_ss;
    logic [PWM_W:0]   w_sum;
    logic [PWM_W-1:0] w_step;
    logic [RTY_W-1:0] w_retry_inc;

    pwm_step_timer #(.DIV_W(DIV_W)) u_step (
        .clk(wb_clk_i), .rst_n(RESET_n),
        .i_inc(r_state == S_RAMP && CYCLE), .i_clr(r_state != S_RAMP),
        .i_div(STEP_DIV), .o_tc(w_step_tc)
    );
    pwm_step_timer #(.DIV_W(DIV_W)) u_cool (
        .clk(wb_clk_i), .rst_n(RESET_n),
        .i_inc(r_state == S_COOL), .i_clr(r_state != S_COOL),
        .i_div(COOL_DIV), .o_tc(w_cool_tc)
    );

    assign w_active    = r_state == S_ARM || r_state == S_RAMP || r_state == S_RUN;
    assign w_fault     = FAULT_DETECT && w_active;
    assign w_disable   = !ENABLE && (w_active || r_state == S_COOL);
    assign w_retry_inc = r_retry + 1'b1;
    assign w_ss        = (STEP_SIZE == 4'd0) ? 4'(EFF_MIN) : STEP_SIZE;
    // Extra sum bit keeps the saturation compare correct near full scale
    assign w_sum       = (PWM_W+1)'(r_pwm) + (PWM_W+1)'(w_ss);
    assign w_step      = (w_sum > (PWM_W+1)'(TARGET_PWM)) ? TARGET_PWM : w_sum[PWM_W-1:0];

    always_ff @(posedge wb_clk_i or negedge RESET_n)
        if (!RESET_n) begin
            r_state <= S_IDLE;
            r_pwm   <= '0;
            r_rst_n <= 1'b0;
            r_at    <= 1'b0;
            r_lock  <= 1'b0;
            r_retry <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_fault) begin
                r_irq   <= 1'b1;
                r_retry <= w_retry_inc;
                r_pwm   <= '0;
                r_rst_n <= 1'b0;
                r_at    <= 1'b0;
                r_lock  <= w_retry_inc == RTY_W'(RETRY_MAX);
                r_state <= (w_retry_inc == RTY_W'(RETRY_MAX)) ? S_LOCKOUT : S_COOL;
            end else if (w_disable) begin
                r_state <= S_IDLE;
                r_retry <= '0;
                r_pwm   <= '0;
                r_rst_n <= 1'b0;
                r_at    <= 1'b0;
            end else begin
                if (CLR_LOCKOUT)
                    r_retry <= '0;
                case (r_state)
                    S_IDLE:
                        if (ENABLE) begin
                            r_state <= S_ARM;
                            r_rst_n <= 1'b1;
                        end
                    S_ARM:
                        if (CYCLE)
                            r_state <= S_RAMP;
                    S_RAMP:
                        if (CYCLE && TARGET_PWM <= r_pwm) begin
                            r_pwm   <= TARGET_PWM;
                            r_state <= S_RUN;
                            r_at    <= 1'b1;
                        end else if (w_step_tc) begin
                            r_pwm <= w_step;
                            if (w_step == TARGET_PWM) begin
                                r_state <= S_RUN;
                                r_at    <= 1'b1;
                            end
                        end
                    S_RUN:
                        if (TARGET_PWM > r_pwm) begin
                            r_state <= S_RAMP;
                            r_at    <= 1'b0;
                        end else if (CYCLE && TARGET_PWM < r_pwm)
                            r_pwm <= TARGET_PWM;
                    S_COOL:
                        if (w_cool_tc) begin
                            r_state <= ENABLE ? S_ARM : S_IDLE;
                            r_rst_n <= ENABLE;
                        end
                    S_LOCKOUT:
                        if (CLR_LOCKOUT) begin
                            r_state <= S_IDLE;
                            r_lock  <= 1'b0;
                        end
                    default: begin
                        r_state <= S_IDLE;
                        r_pwm   <= '0;
                        r_rst_n <= 1'b0;
                        r_at    <= 1'b0;
                        r_lock  <= 1'b0;
                    end
                endcase
            end
        end

    assign DRV_RESET_n = r_rst_n;
    assign DRV_PWM     = r_pwm;
    assign STATE       = r_state;
    assign AT_TARGET   = r_at;
    assign LOCKOUT     = r_lock;
    assign RETRY_CNT   = r_retry;
    assign FAULT_IRQ   = r_irq;
endmodule
